// File: rtl/mdu_unit.sv
// mdu_unit: E-stage multiply/divide unit holding HI/LO, with cycle-exact busy.
// Ports: clk, reset_n, start/op/a/b request, busy, hi, lo.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES)
                      ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic [CW-1:0] cnt;
  logic [31:0]   hi_tmp;
  logic [31:0]   lo_tmp;
  logic          wr_pend;

  logic          is_mul;
  logic          is_div;
  logic          is_mthi;
  logic          is_mtlo;
  logic          sgn;
  logic          neg_q;
  logic [31:0]   abs_a;
  logic [31:0]   abs_b;
  logic [31:0]   dvs;
  logic [31:0]   quo;
  logic [31:0]   rem;
  logic [63:0]   prod;
  logic [31:0]   res_hi;
  logic [31:0]   res_lo;

  assign busy = (cnt != '0);

  always_comb begin
    is_mul  = (op == OP_MULT) || (op == OP_MULTU);
    is_div  = (op == OP_DIV)  || (op == OP_DIVU);
    is_mthi = (op == OP_MTHI);
    is_mtlo = (op == OP_MTLO);
  end

  // Signed ops run on magnitudes; sign is reapplied afterwards,
  // which also makes 0x80000000 / -1 fall out as 0x80000000 rem 0.
  always_comb begin
    sgn    = (op == OP_MULT) || (op == OP_DIV);
    abs_a  = (sgn && a[31]) ? -a : a;
    abs_b  = (sgn && b[31]) ? -b : b;
    neg_q  = sgn & (a[31] ^ b[31]);
    prod   = {32'b0, abs_a} * {32'b0, abs_b};
    dvs    = (abs_b == '0) ? 32'd1 : abs_b;
    quo    = abs_a / dvs;
    rem    = abs_a % dvs;
    res_hi = '0;
    res_lo = '0;
    if (is_mul) begin
      {res_hi, res_lo} = neg_q ? -prod : prod;
    end else begin
      res_lo = neg_q ? -quo : quo;
      res_hi = (sgn && a[31]) ? -rem : rem;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      hi_tmp  <= '0;
      lo_tmp  <= '0;
      wr_pend <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1) && wr_pend) begin
        hi <= hi_tmp;
        lo <= lo_tmp;
      end
    end else if (start) begin
      unique case (1'b1)
        is_mul: begin
          cnt     <= CW'(MULT_CYCLES);
          hi_tmp  <= res_hi;
          lo_tmp  <= res_lo;
          wr_pend <= 1'b1;
        end
        is_div: begin
          cnt     <= CW'(DIV_CYCLES);
          hi_tmp  <= res_hi;
          lo_tmp  <= res_lo;
          wr_pend <= (b != '0);
        end
        is_mthi: hi <= a;
        is_mtlo: lo <= a;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed + random checks of mdu_unit against
// an arithmetic model of HI/LO and the busy schedule.
module tb_mdu_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors = 0;
  int misses  = 0;

  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;

  mdu_unit #(
    .MULT_CYCLES(MC),
    .DIV_CYCLES (DC)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      misses++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [2:0] o,
                                input logic [31:0] x,
                                input logic [31:0] y,
                                inout logic [31:0] h,
                                inout logic [31:0] l,
                                output int n);
    longint          ps;
    longint unsigned pu;
    int              sx;
    int              sy;
    n = 0;
    case (o)
      3'd1: begin
        ps = longint'($signed(x)) * longint'($signed(y));
        {h, l} = ps;
        n = MC;
      end
      3'd2: begin
        pu = longint'({32'b0, x}) * longint'({32'b0, y});
        {h, l} = pu;
        n = MC;
      end
      3'd3: begin
        n = DC;
        if (y != 0) begin
          if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
            l = x;
            h = 0;
          end else begin
            sx = x;
            sy = y;
            l = sx / sy;
            h = sx % sy;
          end
        end
      end
      3'd4: begin
        n = DC;
        if (y != 0) begin
          l = x / y;
          h = x % y;
        end
      end
      3'd5: h = x;
      3'd6: l = x;
      default: ;
    endcase
  endfunction

  // Called at the negedge of issue cycle t; returns at the
  // negedge of cycle t+N+1 so a following call issues back-to-back.
  task automatic run(input logic [2:0] o, input logic [31:0] x,
                     input logic [31:0] y, input bit intrude);
    logic [31:0] nh;
    logic [31:0] nl;
    int          n;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    chk("busy_issue", 32'(busy), 0);
    nh = mhi;
    nl = mlo;
    model(o, x, y, nh, nl, n);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (intrude && i == 2) begin
        start = 1'b1;
        op    = 3'd5;
        a     = 32'hDEADBEEF;
      end
      if (intrude && i == 3) begin
        start = 1'b1;
        op    = 3'd3;
        b     = $urandom;
      end
      chk("busy_win", 32'(busy), 1);
      chk("hi_hold", hi, mhi);
      chk("lo_hold", lo, mlo);
    end
    @(negedge clk);
    start = 1'b0;
    mhi = nh;
    mlo = nl;
    chk("busy_done", 32'(busy), 0);
    chk("hi_done", hi, mhi);
    chk("lo_done", lo, mlo);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] rx;
    logic [31:0] ry;
    reset_n = 1'b0;
    start   = 1'b0;
    op      = '0;
    a       = '0;
    b       = '0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    reset_n = 1'b1;
    @(negedge clk);

    run(3'd1, 32'hFFFFFFFD, 32'd5, 0);
    chk("mult_hi_k", hi, 32'hFFFFFFFF);
    chk("mult_lo_k", lo, 32'hFFFFFFF1);
    run(3'd2, 32'hFFFFFFFF, 32'd2, 0);
    chk("multu_hi_k", hi, 32'h00000001);
    chk("multu_lo_k", lo, 32'hFFFFFFFE);
    run(3'd3, 32'hFFFFFFF9, 32'd2, 0);
    chk("div_hi_k", hi, 32'hFFFFFFFF);
    chk("div_lo_k", lo, 32'hFFFFFFFD);
    run(3'd4, 32'd7, 32'd2, 0);
    run(3'd3, 32'h80000000, 32'hFFFFFFFF, 0);
    chk("ovf_lo_k", lo, 32'h80000000);
    chk("ovf_hi_k", hi, 32'h0);

    run(3'd5, 32'h11, $urandom, 0);
    run(3'd6, 32'h22, $urandom, 0);
    run(3'd3, $urandom, 32'd0, 0);
    chk("dz_hi_k", hi, 32'h11);
    chk("dz_lo_k", lo, 32'h22);
    run(3'd4, $urandom, 32'd0, 0);

    run(3'd1, $urandom, $urandom, 1);
    run(3'd1, $urandom, $urandom, 0);
    run(3'd0, $urandom, $urandom, 0);
    run(3'd7, $urandom, $urandom, 0);

    for (int k = 0; k < 30; k++) begin
      ro = 3'($urandom_range(0, 7));
      rx = $urandom;
      ry = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) ry = 32'($urandom_range(1, 9));
      run(ro, rx, ry, 0);
    end

    run(3'd5, $urandom | 32'h1, $urandom, 0);
    run(3'd6, $urandom | 32'h1, $urandom, 0);
    start = 1'b1;
    op    = 3'd3;
    a     = $urandom;
    b     = 32'd3;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      chk("rst_pre_busy", 32'(busy), 1);
    end
    #1 reset_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_hi", hi, 0);
    chk("arst_lo", lo, 0);
    mhi = '0;
    mlo = '0;
    #1 reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_busy", 32'(busy), 0);
      chk("post_hi", hi, mhi);
      chk("post_lo", lo, mlo);
    end
    run(3'd2, $urandom, $urandom, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, misses);
    $finish;
  end

endmodule
